data_mem_lsu: RTL and testbench
===============================

# data_mem_lsu

Parametrised, byte-addressable RV32 data memory with an integrated load/store formatter, for the single-cycle and pipelined cores' memory stage. It accepts one request per cycle over a valid/ready handshake and supports LB/LH/LW/LBU/LHU and SB/SH/SW. Misaligned, out-of-range and illegal accesses are flagged and have no side effects. After reset, a built-in sweep FSM zero-clears the array before the first request is accepted.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, at least 4.
- AW, $clog2(DEPTH_WORDS): word-index width; derived, never overridden.

- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserts immediately, deassertion sampled on clk).
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response for the request accepted on the previous edge.
- rsp_rdata  output  32  load result, sign- or zero-extended; 0 for stores and errors.
- rsp_err  output  1  the accepted request was misaligned, out of range, or illegal.
- init_busy  output  1  clear sweep in progress.

## Operation
- FSM states:
  - INIT: a counter idx walks 0 .. DEPTH_WORDS-1 and writes 32'h0 to one word per cycle. When idx reaches DEPTH_WORDS-1 and that write completes, the FSM moves to RUN.
  - RUN: req_ready = 1 and init_busy = 0.
- Reset always enters INIT with idx = 0. A reset during RUN or mid-sweep restarts the sweep from word 0. Memory contents are not touched asynchronously.
- A request is accepted when req_valid && req_ready. The response is not back-pressured.
- Address decode:
  - Word index = req_addr[AW+1:2]; byte lane = req_addr[1:0].
  - Out of range: req_addr >= 4*DEPTH_WORDS.
  - Misaligned: H/HU with addr[0] = 1, or W with addr[1:0] != 0.
  - Illegal: funct3 of 011, 110 or 111, or a store with funct3 of 100 or 101.
- Any error sets rsp_err = 1, forces rsp_rdata = 0 and leaves memory unmodified.
- Stores:
  - Byte-enable merge: SB writes lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}; SW writes all 4 lanes.
  - Unselected bytes are preserved.
- Loads:
  - The selected lane(s) are shifted down to bit 0.
  - B and H sign-extend from bit 7 or bit 15; BU and HU zero-extend; W passes the word through.
- Little-endian throughout.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, init_busy 1.
- Sweep length: DEPTH_WORDS cycles after reset deasserts. req_ready rises on the cycle after the last clearing write.
- Load latency is 1: a load accepted at edge N returns data on rsp_rdata/rsp_valid during the cycle after edge N. The array read is registered at the accept edge.
- Stores commit at the accept edge. rsp_valid pulses for one cycle after the accept edge with rsp_err valid.
- Back-to-back requests are supported, one per cycle. A load accepted the cycle after a store to the same word returns the merged new data.
- When no request is accepted, rsp_valid = 0 and rsp_rdata/rsp_err hold 0.

## Configuration
- DMEM_INIT_CLEAR_EN defined:
  - The INIT sweep is built as described above.
- DMEM_INIT_CLEAR_EN undefined:
  - No INIT state and no idx counter.
  - Reset goes directly to RUN: req_ready = 1 and init_busy = 0 from the first edge after reset deassertion.
  - Array contents are undefined until written (X in simulation).

## Test plan
- Reset, then release with DEPTH_WORDS = 16 -> init_busy = 1 for exactly 16 cycles. After that, LW from any of 0x00..0x3C returns 0x00000000 with rsp_err = 0.
- SW 0x80FF7F01 to 0x10, then LB/LBU at 0x10, 0x11, 0x13 -> LB 0x10 = 0x00000001; LB 0x11 = 0x0000007F; LB 0x13 = 0xFFFFFF80; LBU 0x13 = 0x00000080.
- SH 0xBEEF to 0x22 over word 0x11223344 at 0x20 -> LW 0x20 = 0xBEEF3344. Then LH 0x22 = 0xFFFFBEEF and LHU 0x22 = 0x0000BEEF.
- Errors:
  - LW 0x21 -> rsp_err = 1, rsp_rdata = 0.
  - SH 0x23 -> rsp_err = 1, memory unchanged.
  - LW 0x40 (DEPTH_WORDS = 16) -> rsp_err = 1.
  - Store with funct3 = 100 -> rsp_err = 1.
- Back-to-back SW 0xA5A5A5A5 to 0x08 then LW 0x08 on the next cycle -> rsp_rdata = 0xA5A5A5A5. rsp_valid is high on two consecutive cycles.
- Assert reset mid-sweep at idx = 7, then after a full sweep issue a store to word 3 and assert reset again -> sweep restarts at idx = 0 with init_busy = 1 and all outputs at reset values. After the sweep, word 3 reads 0.

Source files
------------

// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32 data memory with load/store formatting and a one-cycle response.
// Optional post-reset zero-clear sweep is built when DMEM_INIT_CLEAR_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | clear sweep: idx walks 0..DEPTH_WORDS-1 writing zero, no requests
// ST_RUN  | requests accepted, one per cycle
module data_mem_lsu #(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        init_busy_o
);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          run;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          out_of_range, misaligned, illegal, err;
  logic [3:0]    be;
  logic [31:0]   wlane, rword, rshift, ld_fmt, ld_data;
  logic          accept, do_store;
  logic          rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_rdata_q;

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          clr_we;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_we  = 1'b0;
    run     = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_we = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == AW'(DEPTH_WORDS - 1)) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN:  run = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end
`else
  logic run_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  assign run = run_q;
`endif

  assign req_ready_o = run;
  assign init_busy_o = ~run;

  assign widx         = req_addr_i[AW+1:2];
  assign lane         = req_addr_i[1:0];
  assign out_of_range = |req_addr_i[31:AW+2];

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    be         = 4'b0000;
    wlane      = req_wdata_i;
    case (req_funct3_i)
      3'b000: begin
        be    = 4'b0001 << lane;
        wlane = {4{req_wdata_i[7:0]}};
      end
      3'b001: begin
        misaligned = lane[0];
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wlane      = {2{req_wdata_i[15:0]}};
      end
      3'b010: begin
        misaligned = |lane;
        be         = 4'b1111;
      end
      3'b100:  illegal = req_we_i;
      3'b101: begin
        illegal    = req_we_i;
        misaligned = lane[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign err      = out_of_range | misaligned | illegal;
  assign accept   = req_valid_i & run;
  assign do_store = accept & req_we_i & ~err;

  // A store committed at the previous edge is already in the array, so a following load needs no bypass.
  assign rword  = mem_q[widx];
  assign rshift = rword >> {lane, 3'b000};

  always_comb begin
    case (req_funct3_i)
      3'b000:  ld_fmt = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  ld_fmt = {{16{rshift[15]}}, rshift[15:0]};
      3'b010:  ld_fmt = rword;
      3'b100:  ld_fmt = {24'h0, rshift[7:0]};
      3'b101:  ld_fmt = {16'h0, rshift[15:0]};
      default: ld_fmt = 32'h0;
    endcase
  end

  assign ld_data = (err | req_we_i) ? 32'h0 : ld_fmt;

  always_ff @(posedge clk_i) begin
`ifdef DMEM_INIT_CLEAR_EN
    if (clr_we) mem_q[idx_q] <= 32'h0;
`endif
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      rsp_rdata_q <= accept ? ld_data : 32'h0;
      rsp_err_q   <= accept & err;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu (DEPTH_WORDS = 16); reference memory model predicts every response.
module tb_data_mem_lsu;
  localparam int DW = 16;
`ifdef DMEM_INIT_CLEAR_EN
  localparam int EXP_SWEEP = DW;
`else
  localparam int EXP_SWEEP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, init_busy;
  logic [31:0] rsp_rdata;

  int tests_run = 0;
  int failed = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model[DW];
  int valid_run = 0;
  int valid_peak = 0;

  always #5 clk = ~clk;

  data_mem_lsu #(.DEPTH_WORDS(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .init_busy_o(init_busy)
  );

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rsp_valid === 1'b1) begin
        logic [32:0] e;
        valid_run++;
        if (valid_run > valid_peak) valid_peak = valid_run;
        tests_run++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_rsp: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err, rsp_rdata} !== e)
          begin
            failed++;
            $display("FAIL rsp: got err=%b rdata=%h, required err=%b rdata=%h",
                     rsp_err, rsp_rdata, e[32], e[31:0]);
          end
        end
      end else begin
        valid_run = 0;
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
          failed++;
          $display("FAIL idle_rsp: got valid=%b rdata=%h err=%b, required 0/0/0", rsp_valid, rsp_rdata, rsp_err);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    logic        err;
    logic [31:0] w, s, r;
    int          idx, lane;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      failed++;
      $display("FAIL req_ready: got %b, required 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    idx  = int'(addr[5:2]);
    lane = int'(addr[1:0]);
    err  = (addr >= 32'(4 * DW));
    case (f3)
      3'b000: ;
      3'b001: if (addr[0]) err = 1'b1;
      3'b010: if (addr[1:0] != 2'b00) err = 1'b1;
      3'b100: if (we) err = 1'b1;
      3'b101: if (we || addr[0]) err = 1'b1;
      default: err = 1'b1;
    endcase
    r = 32'h0;
    if (!err) begin
      w = model[idx];
      if (we) begin
        if (f3 == 3'b000)      w[8*lane +: 8]  = wd[7:0];
        else if (f3 == 3'b001) w[8*lane +: 16] = wd[15:0];
        else                   w = wd;
        model[idx] = w;
      end else begin
        s = w >> (8 * lane);
        case (f3)
          3'b000:  r = {{24{s[7]}}, s[7:0]};
          3'b001:  r = {{16{s[15]}}, s[15:0]};
          3'b100:  r = {24'h0, s[7:0]};
          3'b101:  r = {16'h0, s[15:0]};
          default: r = w;
        endcase
      end
    end
    exp_q.push_back({err, r});
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (n) @(negedge clk);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
`ifdef DMEM_INIT_CLEAR_EN
    for (int i = 0; i < DW; i++) model[i] = 32'h0;
`endif
    #1;
  endtask

  task automatic release_reset(output int n);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (init_busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < DW; i++) model[i] = 32'h0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      failed++;
      $display("FAIL reset_vals: got ready=%b valid=%b rdata=%h err=%b busy=%b, required 0 0 0 0 1",
               req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy);
    end
    release_reset(n);
    tests_run++;
    if (n !== EXP_SWEEP) begin
      failed++;
      $display("FAIL sweep_len: got %0d cycles busy, required %0d", n, EXP_SWEEP);
    end
    tests_run++;
    if (req_ready !== 1'b1 || init_busy !== 1'b0) begin
      failed++;
      $display("FAIL run_entry: got ready=%b busy=%b, required 1 0", req_ready, init_busy);
    end
  endtask

  task automatic test_cleared();
`ifndef DMEM_INIT_CLEAR_EN
    for (int i = 0; i < DW; i++) issue(1'b1, 3'b010, 32'(4 * i), 32'h0);
`endif
    for (int i = 0; i < DW; i++) issue(1'b0, 3'b010, 32'(4 * i), 32'h0);
    idle(2);
  endtask

  task automatic test_byte_loads();
    issue(1'b1, 3'b010, 32'h10, 32'h80FF7F01);
    issue(1'b0, 3'b000, 32'h10, 32'h0);
    issue(1'b0, 3'b000, 32'h11, 32'h0);
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    issue(1'b0, 3'b100, 32'h12, 32'h0);
    issue(1'b0, 3'b001, 32'h12, 32'h0);
    idle(2);
  endtask

  task automatic test_half();
    issue(1'b1, 3'b010, 32'h20, 32'h11223344);
    issue(1'b1, 3'b001, 32'h22, 32'h1234BEEF);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    issue(1'b0, 3'b001, 32'h22, 32'h0);
    issue(1'b0, 3'b101, 32'h22, 32'h0);
    issue(1'b1, 3'b000, 32'h21, 32'hFFFFFFAA);
    issue(1'b1, 3'b001, 32'h24, 32'hCAFE8001);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    issue(1'b0, 3'b001, 32'h24, 32'h0);
    idle(2);
  endtask

  task automatic test_errors();
    issue(1'b0, 3'b010, 32'h21, 32'h0);
    issue(1'b1, 3'b001, 32'h23, 32'h5555);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    issue(1'b1, 3'b100, 32'h20, 32'h77);
    issue(1'b1, 3'b101, 32'h20, 32'h77);
    issue(1'b0, 3'b011, 32'h20, 32'h0);
    issue(1'b1, 3'b110, 32'h20, 32'h0);
    issue(1'b0, 3'b001, 32'h21, 32'h0);
    issue(1'b1, 3'b000, 32'h41, 32'h99);
    issue(1'b1, 3'b010, 32'h80000020, 32'h12345678);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    idle(2);
  endtask

  task automatic test_back_to_back();
    valid_peak = 0;
    issue(1'b1, 3'b010, 32'h08, 32'hA5A5A5A5);
    issue(1'b0, 3'b010, 32'h08, 32'h0);
    idle(3);
    tests_run++;
    if (valid_peak !== 2) begin
      failed++;
      $display("FAIL b2b_valid_run: got %0d consecutive, required 2", valid_peak);
    end
    issue(1'b1, 3'b000, 32'h0A, 32'h3C);
    issue(1'b0, 3'b010, 32'h08, 32'h0);
    issue(1'b1, 3'b001, 32'h08, 32'h9001);
    issue(1'b0, 3'b001, 32'h08, 32'h0);
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 4 * DW + 11));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    for (int i = 0; i < DW; i++) issue(1'b0, 3'b010, 32'(4 * i), 32'h0);
    idle(2);
  endtask

  task automatic test_reset_restart();
`ifdef DMEM_INIT_CLEAR_EN
    int n;
    assert_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    assert_reset();
    tests_run++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      failed++;
      $display("FAIL midsweep_reset_vals: got ready=%b valid=%b rdata=%h err=%b busy=%b",
               req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy);
    end
    release_reset(n);
    tests_run++;
    if (n !== DW) begin
      failed++;
      $display("FAIL midsweep_restart_len: got %0d, required %0d", n, DW);
    end
    issue(1'b1, 3'b010, 32'h0C, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h0C, 32'h0);
    idle(2);
    assert_reset();
    tests_run++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      failed++;
      $display("FAIL run_reset_vals: got ready=%b valid=%b rdata=%h err=%b busy=%b",
               req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy);
    end
    release_reset(n);
    tests_run++;
    if (n !== DW) begin
      failed++;
      $display("FAIL run_restart_len: got %0d, required %0d", n, DW);
    end
    issue(1'b0, 3'b010, 32'h0C, 32'h0);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    idle(2);
`endif
  endtask

  initial begin
    test_reset();
    test_cleared();
    test_byte_loads();
    test_half();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_restart();
    idle(3);
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL missing_rsp: got %0d responses outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
